// File: rtl/pong_pkg.sv
// Shared pong geometry, game/update-step enums and the BCD digit helper.
package pong_pkg;

  // Screen and playfield geometry, shared with the renderer.
  localparam int SCR_W    = 640;
  localparam int SCR_H    = 480;
  localparam int TOP      = 128;
  localparam int BOTTOM   = SCR_H - 10;
  localparam int PAD_H    = 48;
  localparam int PAD_L_X0 = 16;
  localparam int PAD_L_X1 = 24;
  localparam int PAD_R_X0 = 616;
  localparam int PAD_R_X1 = 624;
  localparam int BALL_SZ  = 8;

  // Ball home position and paddle start offset.
  localparam logic [9:0] CENTRE_X  = 10'd324;
  localparam logic [9:0] CENTRE_Y  = 10'd303;
  localparam logic [9:0] PAD_START = 10'd147;

  // Ball coordinates are the pixel just past its bottom-right corner, so the
  // collision windows sit a few pixels off the raw paddle/wall edges.
  localparam logic [9:0] WALL_TOP_Y = 10'(TOP + 10);
  localparam logic [9:0] WALL_BOT_Y = 10'(BOTTOM - 1);
  localparam logic [9:0] PAD_L_XLO  = 10'(PAD_L_X0 + 1);
  localparam logic [9:0] PAD_L_XHI  = 10'(PAD_L_X1 + 6);
  localparam logic [9:0] PAD_L_BNC  = 10'(PAD_L_X1 + BALL_SZ - 1);
  localparam logic [9:0] PAD_R_XLO  = 10'(PAD_R_X0 + 1);
  localparam logic [9:0] PAD_R_XHI  = 10'(PAD_R_X1);
  localparam logic [9:0] PAD_R_BNC  = 10'(PAD_R_X0);
  localparam int         PAD_Y_LO   = 2;
  localparam int         PAD_Y_HI   = PAD_H + 6;
  localparam logic [9:0] GOAL_L_X   = 10'(BALL_SZ);
  localparam logic [9:0] GOAL_R_X   = 10'(SCR_W);

  typedef enum logic [1:0] {
    SERVE_WAIT,
    PLAY,
    PAUSE,
    GAME_OVER
  } game_state_t;

  typedef enum logic [2:0] {
    IDLE,
    S_PAD,
    S_BALL,
    S_COLL,
    S_GOAL
  } step_t;

  // Single BCD digit increment that sticks at 9.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd9 : d + 4'd1;
  endfunction

endpackage

// File: rtl/pong_paddle_step.sv
// Saturating paddle offset update from an up/down button pair.
module pong_paddle_step
  import pong_pkg::*;
#(
  parameter int PAD_SPEED = 4,
  parameter int PAD_MAX   = 294
) (
  input  logic [9:0] offset,
  input  logic       up,
  input  logic       dn,
  output logic [9:0] offset_next
);

  localparam logic [9:0]  SPEED = 10'(PAD_SPEED);
  localparam logic [10:0] LIMIT = 11'(PAD_MAX);

  logic [10:0] sum;

  assign sum = {1'b0, offset} + {1'b0, SPEED};

  // Up-only moves toward 0, down-only toward PAD_MAX; both or neither hold.
  always_comb begin
    offset_next = offset;
    if (up && !dn) begin
      offset_next = (offset >= SPEED) ? offset - SPEED : 10'd0;
    end else if (dn && !up) begin
      offset_next = (sum >= LIMIT) ? LIMIT[9:0] : sum[9:0];
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Per-frame pong sequencer: paddles, ball motion, collisions, goals and score.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int PAD_SPEED    = 4,
  parameter int BALL_SPEED   = 2,
  parameter int PAD_MAX      = 294,
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        btn_l_up,
  input  logic        btn_l_dn,
  input  logic        btn_r_up,
  input  logic        btn_r_dn,
  input  logic        serve,
  output logic [19:0] ball,
  output logic [19:0] ppos,
  output logic [7:0]  score,
  output logic        game_over,
  output logic        busy
);

  localparam int               CNT_W      = $clog2(PAUSE_FRAMES + 2);
  localparam logic [9:0]       BALL_STEP  = 10'(BALL_SPEED);
  localparam logic [3:0]       WIN_DIGIT  = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_FRAMES);

  step_t            step;
  game_state_t      gstate;
  logic [9:0]       bx, by, pl, pr;
  logic [9:0]       pl_next, pr_next;
  logic             vx_pos, vy_pos;
  logic [3:0]       sl, sr, sl_inc, sr_inc;
  logic [CNT_W-1:0] pause_cnt;
  logic [9:0]       coll_x, coll_y;
  logic             coll_vx, coll_vy;

  assign ball   = {by, bx};
  assign ppos   = {pr, pl};
  assign score  = {sr, sl};
  assign sl_inc = bcd_inc(sl);
  assign sr_inc = bcd_inc(sr);

  pong_paddle_step #(.PAD_SPEED(PAD_SPEED), .PAD_MAX(PAD_MAX)) u_pad_l (
    .offset      (pl),
    .up          (btn_l_up),
    .dn          (btn_l_dn),
    .offset_next (pl_next)
  );

  pong_paddle_step #(.PAD_SPEED(PAD_SPEED), .PAD_MAX(PAD_MAX)) u_pad_r (
    .offset      (pr),
    .up          (btn_r_up),
    .dn          (btn_r_dn),
    .offset_next (pr_next)
  );

  // True when ball row y overlaps the paddle whose offset is p.
  function automatic logic in_pad(input logic [9:0] y, input logic [9:0] p);
    logic [10:0] lo;
    logic [10:0] hi;
    lo = {1'b0, p} + 11'(TOP + PAD_Y_LO);
    hi = {1'b0, p} + 11'(TOP + PAD_Y_HI);
    return ({1'b0, y} >= lo) && ({1'b0, y} <= hi);
  endfunction

  // Wall and paddle bounces, all judged on the pre-step position/velocity.
  always_comb begin
    coll_x  = bx;
    coll_y  = by;
    coll_vx = vx_pos;
    coll_vy = vy_pos;
    if (!vy_pos && by <= WALL_TOP_Y) begin
      coll_y  = WALL_TOP_Y;
      coll_vy = 1'b1;
    end else if (vy_pos && by >= WALL_BOT_Y) begin
      coll_y  = WALL_BOT_Y;
      coll_vy = 1'b0;
    end
    if (!vx_pos && bx >= PAD_L_XLO && bx <= PAD_L_XHI && in_pad(by, pl)) begin
      coll_x  = PAD_L_BNC;
      coll_vx = 1'b1;
    end else if (vx_pos && bx >= PAD_R_XLO && bx <= PAD_R_XHI && in_pad(by, pr)) begin
      coll_x  = PAD_R_BNC;
      coll_vx = 1'b0;
    end
  end

  // Update sequencer and game FSM; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step      <= IDLE;
      gstate    <= SERVE_WAIT;
      busy      <= 1'b0;
      game_over <= 1'b0;
      bx        <= CENTRE_X;
      by        <= CENTRE_Y;
      vx_pos    <= 1'b1;
      vy_pos    <= 1'b1;
      pl        <= PAD_START;
      pr        <= PAD_START;
      sl        <= 4'd0;
      sr        <= 4'd0;
      pause_cnt <= '0;
    end else begin
      unique case (step)
        IDLE: begin
          if (frame_tick) begin
            step <= S_PAD;
            busy <= 1'b1;
          end
        end
        S_PAD: begin
          step <= S_BALL;
          if (gstate != GAME_OVER) begin
            pl <= pl_next;
            pr <= pr_next;
          end
        end
        S_BALL: begin
          step <= S_COLL;
          if (gstate == PLAY) begin
            bx <= vx_pos ? bx + BALL_STEP : bx - BALL_STEP;
            by <= vy_pos ? by + BALL_STEP : by - BALL_STEP;
          end
        end
        S_COLL: begin
          step <= S_GOAL;
          if (gstate == PLAY) begin
            bx     <= coll_x;
            by     <= coll_y;
            vx_pos <= coll_vx;
            vy_pos <= coll_vy;
          end
        end
        S_GOAL: begin
          step <= IDLE;
          busy <= 1'b0;
          unique case (gstate)
            SERVE_WAIT: begin
              if (serve) gstate <= PLAY;
            end
            PLAY: begin
              if (bx <= GOAL_L_X) begin
                sr     <= sr_inc;
                vx_pos <= 1'b0;
                if (sr_inc == WIN_DIGIT) begin
                  gstate    <= GAME_OVER;
                  game_over <= 1'b1;
                end else begin
                  gstate    <= PAUSE;
                  pause_cnt <= PAUSE_LOAD;
                end
              end else if (bx >= GOAL_R_X) begin
                sl     <= sl_inc;
                vx_pos <= 1'b1;
                if (sl_inc == WIN_DIGIT) begin
                  gstate    <= GAME_OVER;
                  game_over <= 1'b1;
                end else begin
                  gstate    <= PAUSE;
                  pause_cnt <= PAUSE_LOAD;
                end
              end
            end
            PAUSE: begin
              // The frame whose decrement reaches zero also re-centres.
              if (pause_cnt <= CNT_W'(1)) begin
                pause_cnt <= '0;
                bx        <= CENTRE_X;
                by        <= CENTRE_Y;
                vy_pos    <= 1'b1;
                gstate    <= SERVE_WAIT;
              end else begin
                pause_cnt <= pause_cnt - CNT_W'(1);
              end
            end
            GAME_OVER: begin
              if (serve) begin
                sl        <= 4'd0;
                sr        <= 4'd0;
                bx        <= CENTRE_X;
                by        <= CENTRE_Y;
                gstate    <= SERVE_WAIT;
                game_over <= 1'b0;
              end
            end
            default: gstate <= SERVE_WAIT;
          endcase
        end
        default: begin
          step <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: frame-level game model plus directed scenarios.
module tb_pong_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, frame_tick, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, serve;
  logic [19:0] ball, ppos;
  logic [7:0]  score;
  logic        game_over, busy;

  pong_game_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_l_up   (btn_l_up),
    .btn_l_dn   (btn_l_dn),
    .btn_r_up   (btn_r_up),
    .btn_r_dn   (btn_r_dn),
    .serve      (serve),
    .ball       (ball),
    .ppos       (ppos),
    .score      (score),
    .game_over  (game_over),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Game model: mode 0 waiting for serve, 1 in play, 2 paused, 3 game over.
  int m_x, m_y, m_vx, m_vy, m_pl, m_pr, m_sl, m_sr, m_cnt, m_mode;

  logic [19:0] e_ball, e_ppos;
  logic [7:0]  e_score;
  logic        e_go, e_busy;
  logic        chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  task automatic m_reset();
    m_x = 324; m_y = 303; m_vx = 1; m_vy = 1;
    m_pl = 147; m_pr = 147; m_sl = 0; m_sr = 0; m_cnt = 0; m_mode = 0;
  endtask

  task automatic m_sync();
    e_ball  = {m_y[9:0], m_x[9:0]};
    e_ppos  = {m_pr[9:0], m_pl[9:0]};
    e_score = {m_sr[3:0], m_sl[3:0]};
    e_go    = (m_mode == 3);
  endtask

  function automatic int m_move(input int v, input logic up, input logic dn);
    if (up && !dn) return (v - 4 < 0) ? 0 : v - 4;
    if (dn && !up) return (v + 4 > 294) ? 294 : v + 4;
    return v;
  endfunction

  task automatic m_pad();
    if (m_mode != 3) begin
      m_pl = m_move(m_pl, btn_l_up, btn_l_dn);
      m_pr = m_move(m_pr, btn_r_up, btn_r_dn);
    end
  endtask

  task automatic m_ball();
    if (m_mode == 1) begin
      m_x = (m_x + 2 * m_vx + 1024) % 1024;
      m_y = (m_y + 2 * m_vy + 1024) % 1024;
    end
  endtask

  task automatic m_coll();
    int x0, y0, vx0, vy0;
    if (m_mode == 1) begin
      x0 = m_x; y0 = m_y; vx0 = m_vx; vy0 = m_vy;
      if (vy0 < 0 && y0 <= 138) begin m_y = 138; m_vy = 1; end
      if (vy0 > 0 && y0 >= 469) begin m_y = 469; m_vy = -1; end
      if (vx0 < 0 && x0 >= 17 && x0 <= 30 && y0 >= 130 + m_pl && y0 <= 182 + m_pl) begin
        m_x = 31; m_vx = 1;
      end
      if (vx0 > 0 && x0 >= 617 && x0 <= 624 && y0 >= 130 + m_pr && y0 <= 182 + m_pr) begin
        m_x = 616; m_vx = -1;
      end
    end
  endtask

  task automatic m_goal();
    case (m_mode)
      0: if (serve) m_mode = 1;
      1: begin
        if (m_x <= 8) begin
          m_sr = (m_sr < 9) ? m_sr + 1 : 9;
          m_vx = -1;
          if (m_sr == 9) m_mode = 3; else begin m_mode = 2; m_cnt = 60; end
        end else if (m_x >= 640) begin
          m_sl = (m_sl < 9) ? m_sl + 1 : 9;
          m_vx = 1;
          if (m_sl == 9) m_mode = 3; else begin m_mode = 2; m_cnt = 60; end
        end
      end
      2: begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin m_x = 324; m_y = 303; m_vy = 1; m_mode = 0; end
      end
      default: if (serve) begin m_sl = 0; m_sr = 0; m_x = 324; m_y = 303; m_mode = 0; end
    endcase
  endtask

  // One full frame; optionally pulse frame_tick again while busy.
  task automatic frame(input bit extra);
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0; e_busy = 1'b1;
    @(posedge clk); #1 m_pad(); m_sync(); if (extra) frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0; m_ball(); m_sync();
    @(posedge clk); #1 m_coll(); m_sync();
    @(posedge clk); #1 m_goal(); e_busy = 1'b0; m_sync();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0; m_reset(); e_busy = 1'b0; m_sync();
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // Every cycle the visible outputs must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ball", 32'(ball), 32'(e_ball));
      check("ppos", 32'(ppos), 32'(e_ppos));
      check("score", 32'(score), 32'(e_score));
      check("game_over", 32'(game_over), 32'(e_go));
      check("busy", 32'(busy), 32'(e_busy));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int bc;
    rst_n = 1'b0; frame_tick = 1'b0; serve = 1'b0;
    btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;
    m_reset(); e_busy = 1'b0; m_sync();
    #1 chk_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    check("reset_ball", 32'(ball), 32'h4BD44);
    check("reset_ppos", 32'(ppos), 32'h24C93);
    check("reset_score", 32'(score), 32'h00);
    check("reset_go", 32'(game_over), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Single frame in SERVE_WAIT: busy for exactly four cycles, ball held.
    bc = 0;
    fork
      frame(1'b0);
      repeat (7) begin @(posedge clk); #2 if (busy) bc++; end
    join
    check("busy_cycles", 32'(bc), 32'd4);
    check("wait_ball", 32'(ball), 32'h4BD44);

    // Left paddle up to the top stop, then both buttons, then right down.
    btn_l_up = 1'b1;
    for (int f = 1; f <= 40; f++) begin
      frame(1'b0);
      if (f == 36) check("pl_f36", 32'(ppos[9:0]), 32'd3);
      if (f == 37) check("pl_f37", 32'(ppos[9:0]), 32'd0);
    end
    check("pl_f40", 32'(ppos[9:0]), 32'd0);
    btn_l_dn = 1'b1;
    repeat (5) frame(1'b0);
    check("pl_both", 32'(ppos[9:0]), 32'd0);
    btn_l_up = 1'b0; btn_l_dn = 1'b0;
    btn_r_dn = 1'b1;
    for (int f = 1; f <= 40; f++) begin
      frame(1'b0);
      if (f == 36) check("pr_f36", 32'(ppos[19:10]), 32'd291);
      if (f == 37) check("pr_f37", 32'(ppos[19:10]), 32'd294);
    end
    check("pr_f40", 32'(ppos[19:10]), 32'd294);
    btn_r_dn = 1'b0;

    // Serve, then first ball move down-right.
    serve = 1'b1; frame(1'b0); serve = 1'b0;
    check("serve_ball", 32'(ball), 32'h4BD44);
    frame(1'b0);
    check("first_move", 32'(ball), 32'h4C546);

    // Reset in the middle of an update sequence.
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0; e_busy = 1'b1;
    @(posedge clk); #1 m_pad(); m_sync();
    #2 rst_n = 1'b0; m_reset(); e_busy = 1'b0; m_sync();
    #1 check("midrst_ball", 32'(ball), 32'h4BD44);
    check("midrst_ppos", 32'(ppos), 32'h24C93);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Right paddle at 159 catches the ball; left paddle at 147 misses it.
    btn_r_dn = 1'b1; repeat (3) frame(1'b0); btn_r_dn = 1'b0;
    check("pr_159", 32'(ppos[19:10]), 32'd159);
    serve = 1'b1; frame(1'b0); serve = 1'b0;
    for (int n = 1; n <= 147; n++) begin
      frame(1'b0);
      if (n == 83) check("bottom_bounce", 32'(ball), 32'h755EA);
    end
    check("right_bounce", 32'(ball), 32'h55668);
    check("right_bounce_score", 32'(score), 32'h00);
    repeat (102) frame(1'b0);
    check("top_bounce", 32'(ball), 32'h2299C);
    frame(1'b0);
    check("top_after", 32'(ball), 32'h2319A);
    repeat (201) frame(1'b0);
    check("right_goal_score", 32'(score), 32'h10);
    check("right_goal_ball", 32'(ball), 32'h63408);
    repeat (59) frame(1'b0);
    check("pause_frozen", 32'(ball), 32'h63408);
    frame(1'b0);
    check("pause_recentre", 32'(ball), 32'h4BD44);
    serve = 1'b1; frame(1'b0); serve = 1'b0;
    frame(1'b0);
    check("serve_left", 32'(ball), 32'h4C542);

    // Nine left goals to game over.
    do_reset();
    serve = 1'b1;
    for (int g = 1; g <= 9; g++) begin
      frame(1'b0);
      repeat (158) frame(1'b0);
      check("left_goal", 32'(score), 32'(g));
      if (g < 9) repeat (60) frame(1'b0);
    end
    serve = 1'b0;
    check("win_go", 32'(game_over), 32'd1);
    btn_l_up = 1'b1; btn_r_dn = 1'b1;
    repeat (3) frame(1'b0);
    btn_l_up = 1'b0; btn_r_dn = 1'b0;
    check("over_ppos", 32'(ppos), 32'h24C93);
    check("over_score", 32'(score), 32'h09);
    serve = 1'b1; frame(1'b0); serve = 1'b0;
    check("restart_score", 32'(score), 32'h00);
    check("restart_go", 32'(game_over), 32'd0);
    check("restart_ball", 32'(ball), 32'h4BD44);

    // A tick while busy must not start another sequence.
    frame(1'b1);
    repeat (6) @(posedge clk);
    #1 check("tick_busy_ignored", 32'(busy), 32'd0);

    @(posedge clk); #1 chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
